// File: rtl/pcie_bridge_pkg.sv
// Shared definitions for the PCIe-to-AXI-Lite bridge.
//   - TLP fmt/type constants for single-DW memory requests
//   - RX decoder state encoding (one-hot, 5 bits)
//   - Header field bit positions within the first 64-bit RX beat
//   - BAR priority encoder, also used by the completion generator
package pcie_bridge_pkg;

  // fmt[1] = with data, fmt[0] = 4DW header
  localparam logic [1:0] FmtMRd3  = 2'b00;
  localparam logic [1:0] FmtMRd4  = 2'b01;
  localparam logic [1:0] FmtMWr3  = 2'b10;
  localparam logic [1:0] FmtMWr4  = 2'b11;
  localparam logic [4:0] TypeMem  = 5'b00000;

  typedef enum logic [4:0] {
    StHdr     = 5'b00001,
    StAddr    = 5'b00010,
    StData4   = 5'b00100,
    StDiscard = 5'b01000,
    StPresent = 5'b10000
  } rx_state_e;

  // Beat 0: DW0 in [31:0], DW1 in [63:32]
  localparam int unsigned FmtMsb     = 30;
  localparam int unsigned FmtLsb     = 29;
  localparam int unsigned TypeMsb    = 28;
  localparam int unsigned TypeLsb    = 24;
  localparam int unsigned TcMsb      = 22;
  localparam int unsigned TcLsb      = 20;
  localparam int unsigned EpBit      = 14;
  localparam int unsigned AttrMsb    = 13;
  localparam int unsigned AttrLsb    = 12;
  localparam int unsigned LenMsb     = 9;
  localparam int unsigned LenLsb     = 0;
  localparam int unsigned ReqIdMsb   = 63;
  localparam int unsigned ReqIdLsb   = 48;
  localparam int unsigned TagMsb     = 47;
  localparam int unsigned TagLsb     = 40;
  localparam int unsigned FirstBeMsb = 35;
  localparam int unsigned FirstBeLsb = 32;

  // tuser sideband: BAR0..BAR5 hits; bit 8 (expansion ROM) is never a valid target
  localparam int unsigned BarHitMsb  = 7;
  localparam int unsigned BarHitLsb  = 2;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } bar_enc_t;

  // Lowest-numbered BAR wins when several hit bits are set.
  function automatic bar_enc_t bar_encode(input logic [5:0] bar_hits);
    bar_enc_t r;
    r.hit = 1'b0;
    r.idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (bar_hits[i]) begin
        r.hit = 1'b1;
        r.idx = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pcie_rx_req_decoder.sv
// Receive-side request decoder of the PCIe-to-AXI-Lite bridge.
// Parses single-DW MRd/MWr TLPs (3DW and 4DW headers) from the 64-bit RX
// AXI-Stream and presents each as one held request on mem_req_*, together
// with the completion context (cpl_*). Anything else is drained to tlast and
// counted in drop_count.
//
// Ports:
//   m_axi_aclk, m_axi_aresetn      clock, asynchronous active-low reset
//   m_axis_rx_*                    RX stream from the PCIe block (tready is registered)
//   mem_req_valid/ready            request handshake; valid held until ready
//   mem_req_bar_hit .. write_data  decoded request fields, stable while valid
//   cpl_req_id/tag/tc/attr         completion context, valid with mem_req_valid
//   drop_count                     saturating count of discarded TLPs
module pcie_rx_req_decoder
  import pcie_bridge_pkg::*;
#(
  parameter int TCQ          = 1,
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_aresetn,

  input  logic [C_DATA_WIDTH-1:0] m_axis_rx_tdata,
  input  logic [KEEP_WIDTH-1:0]   m_axis_rx_tkeep,
  input  logic                    m_axis_rx_tlast,
  input  logic                    m_axis_rx_tvalid,
  output logic                    m_axis_rx_tready,
  input  logic [21:0]             m_axis_rx_tuser,

  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [2:0]              mem_req_bar_hit,
  output logic [31:0]             mem_req_pcie_address,
  output logic [3:0]              mem_req_byte_enable,
  output logic                    mem_req_write_readn,
  output logic                    mem_req_phys_func,
  output logic [31:0]             mem_req_write_data,

  output logic [15:0]             cpl_req_id,
  output logic [7:0]              cpl_tag,
  output logic [2:0]              cpl_tc,
  output logic [1:0]              cpl_attr,

  output logic [15:0]             drop_count
);

  rx_state_e   state_q, state_d;
  logic        tready_q, tready_d;
  logic        is_write_q, is_write_d;
  logic        is_4dw_q, is_4dw_d;
  logic [2:0]  bar_q, bar_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] req_id_q, req_id_d;
  logic [7:0]  tag_q, tag_d;
  logic [2:0]  tc_q, tc_d;
  logic [1:0]  attr_q, attr_d;
  logic [15:0] drop_count_q, drop_count_d;

  logic        beat;
  logic        drop_now;
  logic        exp_last;
  logic [1:0]  hdr_fmt;
  logic [4:0]  hdr_type;
  logic [9:0]  hdr_len;
  logic        hdr_ep;
  logic        hdr_ok;
  bar_enc_t    hdr_bar;

  // Inputs only partly decoded (tkeep, ROM hit, reserved header bits) and the
  // simulation-delay parameter, which the zero-delay registers do not need.
  logic unused_inputs;
  assign unused_inputs = ^{m_axis_rx_tkeep, m_axis_rx_tuser, m_axis_rx_tdata, TCQ};

  assign beat     = m_axis_rx_tvalid & tready_q;
  assign hdr_fmt  = m_axis_rx_tdata[FmtMsb:FmtLsb];
  assign hdr_type = m_axis_rx_tdata[TypeMsb:TypeLsb];
  assign hdr_len  = m_axis_rx_tdata[LenMsb:LenLsb];
  assign hdr_ep   = m_axis_rx_tdata[EpBit];
  assign hdr_bar  = bar_encode(m_axis_rx_tuser[BarHitMsb:BarHitLsb]);

  // Poisoned reads are still served; only poisoned writes are dropped.
  assign hdr_ok = (hdr_type == TypeMem) &&
                  (hdr_fmt inside {FmtMRd3, FmtMRd4, FmtMWr3, FmtMWr4}) &&
                  (hdr_len == 10'd1) && hdr_bar.hit && !(hdr_fmt[1] && hdr_ep);

  // Only a 4DW write carries a third beat; every other accepted TLP ends in ADDR.
  assign exp_last = !(is_4dw_q && is_write_q);

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    is_4dw_d   = is_4dw_q;
    bar_d      = bar_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    req_id_d   = req_id_q;
    tag_d      = tag_q;
    tc_d       = tc_q;
    attr_d     = attr_q;
    drop_now   = 1'b0;

    unique case (state_q)
      StHdr: begin
        if (beat) begin
          is_write_d = hdr_fmt[1];
          is_4dw_d   = hdr_fmt[0];
          bar_d      = hdr_bar.idx;
          be_d       = m_axis_rx_tdata[FirstBeMsb:FirstBeLsb];
          req_id_d   = m_axis_rx_tdata[ReqIdMsb:ReqIdLsb];
          tag_d      = m_axis_rx_tdata[TagMsb:TagLsb];
          tc_d       = m_axis_rx_tdata[TcMsb:TcLsb];
          attr_d     = m_axis_rx_tdata[AttrMsb:AttrLsb];
          wdata_d    = 32'h0;
          if (m_axis_rx_tlast) begin
            drop_now = 1'b1;
          end else if (hdr_ok) begin
            state_d = StAddr;
          end else begin
            drop_now = 1'b1;
            state_d  = StDiscard;
          end
        end
      end
      StAddr: begin
        if (beat) begin
          if (is_4dw_q) begin
            addr_d = {m_axis_rx_tdata[63:34], 2'b00};
          end else begin
            addr_d = {m_axis_rx_tdata[31:2], 2'b00};
            if (is_write_q) wdata_d = m_axis_rx_tdata[63:32];
          end
          if (m_axis_rx_tlast == exp_last) begin
            state_d = m_axis_rx_tlast ? StPresent : StData4;
          end else begin
            drop_now = 1'b1;
            state_d  = m_axis_rx_tlast ? StHdr : StDiscard;
          end
        end
      end
      StData4: begin
        if (beat) begin
          wdata_d = m_axis_rx_tdata[31:0];
          if (m_axis_rx_tlast) begin
            state_d = StPresent;
          end else begin
            drop_now = 1'b1;
            state_d  = StDiscard;
          end
        end
      end
      StDiscard: begin
        if (beat && m_axis_rx_tlast) state_d = StHdr;
      end
      StPresent: begin
        if (mem_req_ready) state_d = StHdr;
      end
      default: state_d = StHdr;
    endcase
  end

  // Registered tready tracks the next state, so it drops on the edge that
  // enters PRESENT and returns the cycle after the request handshake.
  assign tready_d = (state_d != StPresent);

  assign drop_count_d = (drop_now && (drop_count_q != 16'hFFFF)) ? drop_count_q + 16'd1
                                                                 : drop_count_q;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q      <= StHdr;
      tready_q     <= 1'b0;
      is_write_q   <= 1'b0;
      is_4dw_q     <= 1'b0;
      bar_q        <= 3'd0;
      addr_q       <= 32'h0;
      be_q         <= 4'h0;
      wdata_q      <= 32'h0;
      req_id_q     <= 16'h0;
      tag_q        <= 8'h0;
      tc_q         <= 3'd0;
      attr_q       <= 2'd0;
      drop_count_q <= 16'h0;
    end else begin
      state_q      <= state_d;
      tready_q     <= tready_d;
      is_write_q   <= is_write_d;
      is_4dw_q     <= is_4dw_d;
      bar_q        <= bar_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      req_id_q     <= req_id_d;
      tag_q        <= tag_d;
      tc_q         <= tc_d;
      attr_q       <= attr_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign m_axis_rx_tready     = tready_q;
  assign mem_req_valid        = (state_q == StPresent);
  assign mem_req_bar_hit      = bar_q;
  assign mem_req_pcie_address = addr_q;
  assign mem_req_byte_enable  = be_q;
  assign mem_req_write_readn  = is_write_q;
  assign mem_req_phys_func    = 1'b0;
  assign mem_req_write_data   = wdata_q;
  assign cpl_req_id           = req_id_q;
  assign cpl_tag              = tag_q;
  assign cpl_tc               = tc_q;
  assign cpl_attr             = attr_q;
  assign drop_count           = drop_count_q;

endmodule

// File: tb/tb_pcie_rx_req_decoder.sv
// Bench for pcie_rx_req_decoder: directed vector table, reset/hold corner
// sequences and randomized TLPs checked against a TLP-level reference model.
module tb_pcie_rx_req_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] tdata = '0;
  logic [7:0]  tkeep = '0;
  logic        tlast = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [21:0] tuser = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [2:0]  mem_req_bar_hit;
  logic [31:0] mem_req_pcie_address;
  logic [3:0]  mem_req_byte_enable;
  logic        mem_req_write_readn;
  logic        mem_req_phys_func;
  logic [31:0] mem_req_write_data;
  logic [15:0] cpl_req_id;
  logic [7:0]  cpl_tag;
  logic [2:0]  cpl_tc;
  logic [1:0]  cpl_attr;
  logic [15:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_drops = 0;

  always #5 clk = ~clk;

  pcie_rx_req_decoder dut (
    .m_axi_aclk           (clk),
    .m_axi_aresetn        (rst_n),
    .m_axis_rx_tdata      (tdata),
    .m_axis_rx_tkeep      (tkeep),
    .m_axis_rx_tlast      (tlast),
    .m_axis_rx_tvalid     (tvalid),
    .m_axis_rx_tready     (tready),
    .m_axis_rx_tuser      (tuser),
    .mem_req_valid        (mem_req_valid),
    .mem_req_ready        (mem_req_ready),
    .mem_req_bar_hit      (mem_req_bar_hit),
    .mem_req_pcie_address (mem_req_pcie_address),
    .mem_req_byte_enable  (mem_req_byte_enable),
    .mem_req_write_readn  (mem_req_write_readn),
    .mem_req_phys_func    (mem_req_phys_func),
    .mem_req_write_data   (mem_req_write_data),
    .cpl_req_id           (cpl_req_id),
    .cpl_tag              (cpl_tag),
    .cpl_tc               (cpl_tc),
    .cpl_attr             (cpl_attr),
    .drop_count           (drop_count)
  );

  typedef struct {
    logic [1:0]  fmt;
    logic [4:0]  typ;
    logic [9:0]  len;
    logic        ep;
    logic [6:0]  bars;   // {ROM, BAR5..BAR0}
    int          nbeats;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] data;
  } tlp_t;

  typedef struct {
    tlp_t       t;
    logic       ok;
    logic [2:0] bar;
    int         hold;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic tlp_t mk(input logic [1:0] fmt, input logic [4:0] typ, input logic [9:0] len,
                              input logic ep, input logic [6:0] bars, input int nbeats,
                              input logic [15:0] rid, input logic [7:0] tag, input logic [2:0] tc,
                              input logic [1:0] attr, input logic [31:0] addr,
                              input logic [31:0] data);
    tlp_t t;
    t.fmt = fmt; t.typ = typ; t.len = len; t.ep = ep; t.bars = bars; t.nbeats = nbeats;
    t.rid = rid; t.tag = tag; t.tc = tc; t.attr = attr; t.be = 4'hF;
    t.addr = addr; t.data = data;
    return t;
  endfunction

  // Wire format of beat i of the TLP (DW0 in the low half).
  function automatic logic [63:0] beat_of(input tlp_t t, input int i);
    logic [31:0] dw0, dw1;
    dw0 = {1'b0, t.fmt, t.typ, 1'b0, t.tc, 5'b0, t.ep, t.attr, 2'b0, t.len};
    dw1 = {t.rid, t.tag, 4'h0, t.be};
    if (i == 0) return {dw1, dw0};
    if (i == 1) return t.fmt[0] ? {t.addr, $urandom} : {t.data, t.addr};
    if (i == 2 && t.fmt == 2'b11) return {32'h0, t.data};
    return {$urandom, $urandom};
  endfunction

  // Reference: a TLP becomes a request iff it is a single-DW memory request
  // to BAR0-5, not a poisoned write, and has exactly its natural beat count.
  task automatic ref_expect(input tlp_t t, output logic ok, output logic [2:0] bar);
    int need;
    int hit;
    need = (t.fmt == 2'b11) ? 3 : 2;
    hit = -1;
    for (int b = 0; b < 6; b++) if (hit < 0 && t.bars[b]) hit = b;
    bar = (hit < 0) ? 3'd0 : 3'(hit);
    ok = (t.typ == 5'd0) && (t.len == 10'd1) && (hit >= 0) && !(t.fmt[1] && t.ep) &&
         (t.nbeats == need);
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last, input logic [21:0] user,
                           input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    tvalid = 1'b1; tdata = d; tlast = last; tuser = user; tkeep = 8'hFF;
    while (tready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tready_wait", {63'b0, tready}, 64'd1);
    @(posedge clk);
    #1;
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic chk_fields(input tlp_t t, input logic [2:0] bar);
    chk("bar_hit", {61'b0, mem_req_bar_hit}, {61'b0, bar});
    chk("address", {32'b0, mem_req_pcie_address}, {32'b0, t.addr[31:2], 2'b00});
    chk("byte_en", {60'b0, mem_req_byte_enable}, {60'b0, t.be});
    chk("write_readn", {63'b0, mem_req_write_readn}, {63'b0, t.fmt[1]});
    chk("write_data", {32'b0, mem_req_write_data}, {32'b0, (t.fmt[1] ? t.data : 32'h0)});
    chk("phys_func", {63'b0, mem_req_phys_func}, 64'd0);
    chk("cpl_req_id", {48'b0, cpl_req_id}, {48'b0, t.rid});
    chk("cpl_tag", {56'b0, cpl_tag}, {56'b0, t.tag});
    chk("cpl_tc", {61'b0, cpl_tc}, {61'b0, t.tc});
    chk("cpl_attr", {62'b0, cpl_attr}, {62'b0, t.attr});
  endtask

  task automatic run_tlp(input tlp_t t, input logic ok, input logic [2:0] bar, input int hold,
                         input int gap_max);
    logic [21:0] user;
    user = {13'b0, t.bars, 2'b00};
    for (int i = 0; i < t.nbeats; i++)
      send_beat(beat_of(t, i), (i == t.nbeats - 1), user,
                (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
    if (!ok) exp_drops++;
    chk("req_valid", {63'b0, mem_req_valid}, {63'b0, ok});
    chk("drop_count", {48'b0, drop_count}, 64'(exp_drops));
    if (ok) begin
      chk("tready_present", {63'b0, tready}, 64'd0);
      chk_fields(t, bar);
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        chk("hold_valid", {63'b0, mem_req_valid}, 64'd1);
        chk("hold_tready", {63'b0, tready}, 64'd0);
        chk("hold_addr", {32'b0, mem_req_pcie_address}, {32'b0, t.addr[31:2], 2'b00});
        chk("hold_tag", {56'b0, cpl_tag}, {56'b0, t.tag});
      end
      @(negedge clk);
      mem_req_ready = 1'b1;
      @(posedge clk);
      #1;
      mem_req_ready = 1'b0;
      chk("post_hs_valid", {63'b0, mem_req_valid}, 64'd0);
      chk("post_hs_tready", {63'b0, tready}, 64'd1);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[14];
    tlp_t t;
    logic ok;
    logic [2:0] bar;

    vecs[0]  = '{mk(2'b10, 5'd0, 10'd1, 1'b0, 7'h01, 2, 16'h0001, 8'h05, 3'd0, 2'd0,
                    32'h0000_0104, 32'hDEAD_BEEF), 1'b1, 3'd0, 0};
    vecs[1]  = '{mk(2'b01, 5'd0, 10'd1, 1'b0, 7'h04, 2, 16'h0100, 8'h1A, 3'd3, 2'd2,
                    32'h0000_0040, 32'h0), 1'b1, 3'd2, 0};
    vecs[2]  = '{mk(2'b10, 5'd0, 10'd2, 1'b0, 7'h01, 3, 16'h0002, 8'h06, 3'd0, 2'd0,
                    32'h0000_0200, 32'h1111_2222), 1'b0, 3'd0, 0};
    vecs[3]  = '{mk(2'b10, 5'd0, 10'd1, 1'b0, 7'h02, 2, 16'h0003, 8'h07, 3'd1, 2'd1,
                    32'h0000_0300, 32'h3333_4444), 1'b1, 3'd1, 10};
    vecs[4]  = '{mk(2'b10, 5'd0, 10'd1, 1'b1, 7'h01, 2, 16'h0004, 8'h08, 3'd0, 2'd0,
                    32'h0000_0400, 32'h5555_6666), 1'b0, 3'd0, 0};
    vecs[5]  = '{mk(2'b00, 5'd0, 10'd1, 1'b0, 7'h00, 2, 16'h0005, 8'h09, 3'd0, 2'd0,
                    32'h0000_0500, 32'h0), 1'b0, 3'd0, 0};
    vecs[6]  = '{mk(2'b00, 5'd0, 10'd1, 1'b0, 7'h01, 1, 16'h0006, 8'h0A, 3'd0, 2'd0,
                    32'h0000_0600, 32'h0), 1'b0, 3'd0, 0};
    vecs[7]  = '{mk(2'b00, 5'd0, 10'd1, 1'b0, 7'h40, 2, 16'h0007, 8'h0B, 3'd0, 2'd0,
                    32'h0000_0700, 32'h0), 1'b0, 3'd0, 0};
    vecs[8]  = '{mk(2'b00, 5'd0, 10'd1, 1'b0, 7'h30, 2, 16'hABCD, 8'h0C, 3'd7, 2'd3,
                    32'h1234_5678, 32'h0), 1'b1, 3'd4, 0};
    vecs[9]  = '{mk(2'b11, 5'd0, 10'd1, 1'b0, 7'h20, 3, 16'h0009, 8'h0D, 3'd2, 2'd0,
                    32'h8000_0010, 32'hCAFE_F00D), 1'b1, 3'd5, 2};
    vecs[10] = '{mk(2'b00, 5'd1, 10'd1, 1'b0, 7'h01, 2, 16'h000A, 8'h0E, 3'd0, 2'd0,
                    32'h0000_0A00, 32'h0), 1'b0, 3'd0, 0};
    vecs[11] = '{mk(2'b11, 5'd0, 10'd1, 1'b0, 7'h01, 2, 16'h000B, 8'h0F, 3'd0, 2'd0,
                    32'h0000_0B00, 32'h7777_8888), 1'b0, 3'd0, 0};
    vecs[12] = '{mk(2'b01, 5'd0, 10'd1, 1'b1, 7'h08, 2, 16'h000C, 8'h10, 3'd0, 2'd0,
                    32'h0000_0C00, 32'h0), 1'b1, 3'd3, 0};
    vecs[13] = '{mk(2'b00, 5'd0, 10'd1, 1'b0, 7'h01, 3, 16'h000D, 8'h11, 3'd0, 2'd0,
                    32'h0000_0D00, 32'h0), 1'b0, 3'd0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tready", {63'b0, tready}, 64'd0);
    chk("rst_valid", {63'b0, mem_req_valid}, 64'd0);
    chk("rst_drop", {48'b0, drop_count}, 64'd0);
    chk("rst_addr", {32'b0, mem_req_pcie_address}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("tready_after_release", {63'b0, tready}, 64'd0);
    @(posedge clk);
    #1;
    chk("tready_first_edge", {63'b0, tready}, 64'd1);

    foreach (vecs[i]) run_tlp(vecs[i].t, vecs[i].ok, vecs[i].bar, vecs[i].hold, 0);

    // Reset while an MWr4 sits in DATA4; the orphaned last beat then reads as a
    // 1-beat TLP and is dropped.
    t = mk(2'b11, 5'd0, 10'd1, 1'b0, 7'h08, 3, 16'h5A5A, 8'h77, 3'd5, 2'd3,
           32'h0000_0F00, 32'h0BAD_CAFE);
    send_beat(beat_of(t, 0), 1'b0, {13'b0, t.bars, 2'b00}, 0);
    send_beat(beat_of(t, 1), 1'b0, {13'b0, t.bars, 2'b00}, 0);
    rst_n = 1'b0;
    #1;
    exp_drops = 0;
    chk("mid_rst_tready", {63'b0, tready}, 64'd0);
    chk("mid_rst_valid", {63'b0, mem_req_valid}, 64'd0);
    chk("mid_rst_tag", {56'b0, cpl_tag}, 64'd0);
    chk("mid_rst_req_id", {48'b0, cpl_req_id}, 64'd0);
    chk("mid_rst_bar", {61'b0, mem_req_bar_hit}, 64'd0);
    chk("mid_rst_addr", {32'b0, mem_req_pcie_address}, 64'd0);
    chk("mid_rst_wr", {63'b0, mem_req_write_readn}, 64'd0);
    chk("mid_rst_drop", {48'b0, drop_count}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(beat_of(t, 2), 1'b1, {13'b0, t.bars, 2'b00}, 0);
    exp_drops++;
    chk("orphan_valid", {63'b0, mem_req_valid}, 64'd0);
    chk("orphan_drop", {48'b0, drop_count}, 64'(exp_drops));
    run_tlp(t, 1'b1, 3'd3, 0, 0);

    // Randomized TLPs against the reference model
    for (int n = 0; n < 80; n++) begin
      t.fmt  = 2'($urandom_range(0, 3));
      t.typ  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      t.len  = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(2, 1023)) : 10'd1;
      t.ep   = ($urandom_range(0, 7) == 0);
      t.bars = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) t.bars = t.bars & 7'h40;
      t.nbeats = (t.fmt == 2'b11) ? 3 : 2;
      if ($urandom_range(0, 4) == 0) t.nbeats = $urandom_range(1, 4);
      t.rid  = 16'($urandom);
      t.tag  = 8'($urandom);
      t.tc   = 3'($urandom);
      t.attr = 2'($urandom);
      t.be   = 4'($urandom);
      t.addr = $urandom;
      t.data = $urandom;
      ref_expect(t, ok, bar);
      run_tlp(t, ok, bar, $urandom_range(0, 3), 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
